data_mem_stage: RTL and testbench
=================================

DATA_MEM_STAGE -- requirements
Module: data_mem_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 valid_in  input  1  instruction present in memory stage this cycle.
REQ-004 Wm  input  1  memory write enable from memory-stage decode.
REQ-005 SM2  input  1  result select: 0 -> alu_res, 1 -> memory read data.
REQ-006 addr  input  8  data memory byte address.
REQ-007 wdata  input  8  store data.
REQ-008 alu_res  input  8  ALU result passed through the stage.
REQ-009 rd_in  input  2  destination register index.
REQ-010 we_in  input  1  register-file write enable for this instruction.
REQ-011 hold  input  1  stall: freeze MEM/WB register, block memory writes.
REQ-012 flush  input  1  kill the instruction currently in the stage.
REQ-013 D_data  output  8  combinational read data, mem[addr].
REQ-014 wb_data  output  8  registered write-back value.
REQ-015 wb_rd  output  2  registered destination index.
REQ-016 wb_we  output  1  registered register-file write enable.
REQ-017 wb_valid  output  1  registered valid for write-back.

Function
REQ-018 Storage SHALL be 256 x 8 bits, addressed directly by addr with no wrap logic; all 8 address bits are used.
REQ-019 D_data SHALL equal mem[addr] combinationally, independent of valid_in, hold and flush.
REQ-020 A write SHALL occur at the rising edge only when valid_in=1, Wm=1, hold=0, flush=0, and rst_n=1.
  - Effect: mem[addr] <= wdata.
REQ-021 On a same-cycle read and write to one address, D_data SHALL return the pre-write value; the new value is visible from the next cycle.
REQ-022 Selected result sel = SM2 ? D_data : alu_res.
REQ-023 With hold=0 and flush=0, each edge SHALL load:
  - wb_data <= sel
  - wb_rd <= rd_in
  - wb_we <= we_in & valid_in
  - wb_valid <= valid_in
REQ-024 With hold=1 and flush=0, every MEM/WB register SHALL keep its value.
REQ-025 With flush=1, the edge SHALL load a bubble regardless of hold:
  - wb_valid=0, wb_we=0
  - wb_data and wb_rd keep their values
REQ-026 Latency: D_data is available in the same cycle; wb_* outputs are valid exactly 1 cycle after the unstalled edge.
REQ-027 When valid_in=0, the stage SHALL NOT write memory and SHALL produce wb_valid=0 and wb_we=0 at the next unstalled edge.
REQ-028 Simultaneous Wm=1 and SM2=1 with valid_in=1 SHALL perform the write and select the pre-write D_data.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately, without waiting for a clock edge, set wb_data=8'h00, wb_rd=2'b00, wb_we=0 and wb_valid=0.
REQ-030 Memory contents SHALL NOT be reset; no write occurs while rst_n=0.
REQ-031 Reset asserted mid-stall or mid-write SHALL discard the in-flight instruction.
REQ-032 The first unstalled edge after rst_n rises SHALL load normally per REQ-023.

Verification
REQ-033 Store/load:
  - Cycle 1: valid_in=1, Wm=1, addr=8'h3C, wdata=8'hA5.
  - Cycle 2: SM2=1, addr=8'h3C, rd_in=2, we_in=1.
  - Required: next edge gives wb_data=8'hA5, wb_rd=2, wb_we=1, wb_valid=1.
REQ-034 ALU pass-through:
  - Stimulus: SM2=0, alu_res=8'h7E, valid_in=1, we_in=1.
  - Required: wb_data=8'h7E one cycle later; memory unchanged.
REQ-035 Hold:
  - Stimulus: store 8'h11 to 8'hFF with hold=1 for 3 cycles.
  - Required: mem[8'hFF] unchanged and wb_* frozen for 3 cycles.
  - Then release hold: write lands on the next edge.
REQ-036 Flush:
  - Stimulus: valid store with flush=1 and hold=1.
  - Required: no memory write; next edge wb_valid=0, wb_we=0.
REQ-037 Read-during-write:
  - Setup: mem[8'h00]=8'h22.
  - Stimulus: write 8'h33 to 8'h00 with SM2=1 in the same cycle.
  - Required: wb_data=8'h22; a following load returns 8'h33.
REQ-038 Async reset:
  - Stimulus: rst_n low between clock edges while wb_valid=1.
  - Required: wb_* zero within the same cycle; a prior stored byte is still readable after reset.

Source files
------------

// File: rtl/data_mem_stage_if.sv
// Memory-stage bus: instruction fields and controls in, read data and MEM/WB register out.
interface data_mem_stage_if;
    logic       valid_in;
    logic       Wm;
    logic       SM2;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] alu_res;
    logic [1:0] rd_in;
    logic       we_in;
    logic       hold;
    logic       flush;
    logic [7:0] D_data;
    logic [7:0] wb_data;
    logic [1:0] wb_rd;
    logic       wb_we;
    logic       wb_valid;

    modport master (
        output valid_in, Wm, SM2, addr, wdata, alu_res, rd_in, we_in, hold, flush,
        input  D_data, wb_data, wb_rd, wb_we, wb_valid
    );

    modport slave (
        input  valid_in, Wm, SM2, addr, wdata, alu_res, rd_in, we_in, hold, flush,
        output D_data, wb_data, wb_rd, wb_we, wb_valid
    );
endinterface

// File: rtl/data_mem_stage.sv
// Pipeline memory stage: 256x8 data memory with asynchronous read, plus the MEM/WB register.
module data_mem_stage (
    input logic            clk,
    input logic            rst_n,
    data_mem_stage_if.slave bus
);
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_c;
    logic [DW-1:0] sel_c;
    logic          wr_en_c;

    // Read is taken before any same-edge write, so a colliding load sees the old byte.
    assign rdata_c    = mem[bus.addr];
    assign bus.D_data = rdata_c;
    assign sel_c      = bus.SM2 ? rdata_c : bus.alu_res;
    assign wr_en_c    = bus.valid_in & bus.Wm & ~bus.hold & ~bus.flush;

    // Memory has no reset; sharing the reset branch keeps writes blocked while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wb_data  <= '0;
            bus.wb_rd    <= '0;
            bus.wb_we    <= 1'b0;
            bus.wb_valid <= 1'b0;
        end else begin
            if (wr_en_c) begin
                mem[bus.addr] <= bus.wdata;
            end
            if (bus.flush) begin
                bus.wb_we    <= 1'b0;
                bus.wb_valid <= 1'b0;
            end else if (!bus.hold) begin
                bus.wb_data  <= sel_c;
                bus.wb_rd    <= bus.rd_in;
                bus.wb_we    <= bus.we_in & bus.valid_in;
                bus.wb_valid <= bus.valid_in;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_stage.sv
// Randomized self-checking bench for data_mem_stage against a behavioural memory/write-back model.
module tb_data_mem_stage;
    logic clk;
    logic rst_n;
    data_mem_stage_if bus();

    data_mem_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_chk;
    int unsigned n_err;

    logic [7:0] m_mem [256];
    logic [7:0] m_data;
    logic [1:0] m_rd;
    logic       m_we;
    logic       m_valid;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic s, input logic [7:0] a,
                         input logic [7:0] wd, input logic [7:0] alu, input logic [1:0] rd,
                         input logic we, input logic h, input logic f);
        bus.valid_in = v;  bus.Wm = w;       bus.SM2 = s;  bus.addr = a;
        bus.wdata = wd;    bus.alu_res = alu; bus.rd_in = rd; bus.we_in = we;
        bus.hold = h;      bus.flush = f;
    endtask

    task automatic check_wb(input string tag);
        check({tag, ".wb_data"},  bus.wb_data,         m_data);
        check({tag, ".wb_rd"},    8'(bus.wb_rd),       8'(m_rd));
        check({tag, ".wb_we"},    8'(bus.wb_we),       8'(m_we));
        check({tag, ".wb_valid"}, 8'(bus.wb_valid),    8'(m_valid));
    endtask

    // Called just after a rising edge with inputs applied; advances one clock.
    task automatic run_cycle(input string tag);
        logic [7:0] sel;
        #2;
        check({tag, ".D_data"}, bus.D_data, m_mem[bus.addr]);
        sel = bus.SM2 ? m_mem[bus.addr] : bus.alu_res;
        if (bus.flush) begin
            m_valid = 1'b0;
            m_we    = 1'b0;
        end else if (!bus.hold) begin
            m_data  = sel;
            m_rd    = bus.rd_in;
            m_we    = bus.we_in & bus.valid_in;
            m_valid = bus.valid_in;
        end
        if (bus.valid_in && bus.Wm && !bus.hold && !bus.flush)
            m_mem[bus.addr] = bus.wdata;
        @(posedge clk);
        #1;
        check_wb(tag);
    endtask

    // Reset asserted between edges and held across one edge; memory must survive untouched.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        m_data = 8'h00; m_rd = 2'b00; m_we = 1'b0; m_valid = 1'b0;
        check_wb({tag, ".async"});
        @(posedge clk);
        #1;
        check_wb({tag, ".held"});
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] saved;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        m_data = 8'h00; m_rd = 2'b00; m_we = 1'b0; m_valid = 1'b0;
        #1;
        check_wb("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill every location so the model knows the whole memory.
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(i), 8'($urandom), 8'($urandom), 2'($urandom), 1'b1, 1'b0, 1'b0);
            run_cycle("fill");
        end

        // Store then load.
        drive(1'b1, 1'b1, 1'b0, 8'h3C, 8'hA5, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        run_cycle("store");
        drive(1'b1, 1'b0, 1'b1, 8'h3C, 8'h00, 8'h00, 2'd2, 1'b1, 1'b0, 1'b0);
        run_cycle("load");
        check("store_load.data",  bus.wb_data,       8'hA5);
        check("store_load.rd",    8'(bus.wb_rd),     8'd2);
        check("store_load.we",    8'(bus.wb_we),     8'd1);
        check("store_load.valid", 8'(bus.wb_valid),  8'd1);

        // ALU pass-through.
        saved = m_mem[8'h40];
        drive(1'b1, 1'b0, 1'b0, 8'h40, 8'h99, 8'h7E, 2'd1, 1'b1, 1'b0, 1'b0);
        run_cycle("alu");
        check("alu.data", bus.wb_data, 8'h7E);
        check("alu.mem",  bus.D_data,  saved);

        // Hold blocks the store and freezes write-back for three cycles.
        saved = m_mem[8'hFF];
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'hFF, 8'h11, 8'($urandom), 2'd3, 1'b1, 1'b1, 1'b0);
            run_cycle("hold");
            check("hold.data",  bus.wb_data, 8'h7E);
            check("hold.mem",   bus.D_data,  saved);
        end
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 8'h11, 8'h00, 2'd3, 1'b1, 1'b0, 1'b0);
        run_cycle("hold_release");
        drive(1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 check("hold_release.mem", bus.D_data, 8'h11);
        run_cycle("after_hold");

        // Flush with hold: no write and a bubble.
        saved = m_mem[8'h55];
        drive(1'b1, 1'b1, 1'b0, 8'h55, 8'hEE, 8'h12, 2'd1, 1'b1, 1'b1, 1'b1);
        run_cycle("flush");
        check("flush.valid", 8'(bus.wb_valid), 8'd0);
        check("flush.we",    8'(bus.wb_we),    8'd0);
        drive(1'b0, 1'b0, 1'b0, 8'h55, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 check("flush.mem", bus.D_data, saved);
        run_cycle("after_flush");

        // Read during write returns the old byte.
        drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h22, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        run_cycle("rdw_setup");
        drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h33, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0);
        run_cycle("rdw");
        check("rdw.old", bus.wb_data, 8'h22);
        drive(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0);
        run_cycle("rdw_load");
        check("rdw.new", bus.wb_data, 8'h33);

        // Async reset with wb_valid high; stored byte survives.
        drive(1'b1, 1'b1, 1'b0, 8'hC3, 8'h5A, 8'h00, 2'd2, 1'b1, 1'b0, 1'b0);
        run_cycle("pre_reset");
        do_reset("reset_mid");
        check("reset_mid.valid", 8'(bus.wb_valid), 8'd0);
        drive(1'b1, 1'b0, 1'b1, 8'hC3, 8'h00, 8'h00, 2'd2, 1'b1, 1'b0, 1'b0);
        run_cycle("post_reset");
        check("post_reset.data", bus.wb_data, 8'h5A);

        // Random traffic with address collisions, stalls, flushes and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 2) == 0), 1'($urandom),
                  ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom),
                  8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 99) == 0)
                do_reset("rand_reset");
            else
                run_cycle("rand");
        end

        // Final sweep of every location with no writes.
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'(i), 8'($urandom), 8'h00, 2'd0, 1'b1, 1'b0, 1'b0);
            run_cycle("sweep");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
